// File: rtl/lane_training_ctrl_if.sv
// rtl/lane_training_ctrl_if.sv - lane controller to timer/PHY signal bundle
interface lane_training_ctrl_if;
    logic lane_disable;
    logic tdisabled_min;
    logic tdisconnect_tx_min;
    logic tconnect_rx_min;
    logic tdisconnect_rx_min;
    logic ttraining_error_timeout;
    logic tgen4_ts1_timeout;
    logic tgen4_ts2_timeout;
    logic ts1_rcvd;
    logic ts2_rcvd;
    logic ts2_tx_done;
    logic fsm_disabled;
    logic disconnected_s;
    logic fsm_training;
    logic ts1_gen4_s;
    logic ts2_gen4_s;
    logic send_ts1;
    logic send_ts2;
    logic cl0_active;
    logic [2:0] lane_state;
    logic training_error;
    logic lane_fail;

    modport master (
        input  lane_disable, tdisabled_min, tdisconnect_tx_min, tconnect_rx_min,
               tdisconnect_rx_min, ttraining_error_timeout, tgen4_ts1_timeout,
               tgen4_ts2_timeout, ts1_rcvd, ts2_rcvd, ts2_tx_done,
        output fsm_disabled, disconnected_s, fsm_training, ts1_gen4_s, ts2_gen4_s,
               send_ts1, send_ts2, cl0_active, lane_state, training_error, lane_fail
    );

    modport slave (
        output lane_disable, tdisabled_min, tdisconnect_tx_min, tconnect_rx_min,
               tdisconnect_rx_min, ttraining_error_timeout, tgen4_ts1_timeout,
               tgen4_ts2_timeout, ts1_rcvd, ts2_rcvd, ts2_tx_done,
        input  fsm_disabled, disconnected_s, fsm_training, ts1_gen4_s, ts2_gen4_s,
               send_ts1, send_ts2, cl0_active, lane_state, training_error, lane_fail
    );
endinterface

// File: rtl/lane_training_ctrl.sv
// rtl/lane_training_ctrl.sv - USB4 lane Disabled/Disconnected/TS1/TS2/CL0 sequencer
module lane_training_ctrl #(
    parameter int TS1_REQ   = 2,
    parameter int TS2_REQ   = 2,
    parameter int TS2_SEND  = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                        sb_clk,
    input  logic                        rst,
    lane_training_ctrl_if.master        bus
);
    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_DISCONN  = 3'd1,
        ST_TS1      = 3'd2,
        ST_TS2      = 3'd3,
        ST_CL0      = 3'd4
    } state_t;

    localparam logic [7:0] TS1_MAX  = 8'(TS1_REQ);
    localparam logic [7:0] TS2R_MAX = 8'(TS2_REQ);
    localparam logic [7:0] TS2T_MAX = 8'(TS2_SEND);
    localparam logic [3:0] LAST_TRY = 4'(MAX_RETRY - 1);

    state_t     state, state_nx;
    logic [7:0] ts1_cnt, ts2_rx_cnt, ts2_tx_cnt;
    logic [7:0] ts1_nx, ts2_rx_nx, ts2_tx_nx;
    logic [3:0] retry_cnt;
    logic       fail, fail_cond, training_error_q, lane_fail_q;

    always_comb begin
        state_nx  = ST_DISABLED;
        fail      = 1'b0;
        ts1_nx    = ts1_cnt;
        ts2_rx_nx = ts2_rx_cnt;
        ts2_tx_nx = ts2_tx_cnt;
        fail_cond = 1'b0;

        // Counts include this cycle's pulse so advancement needs no extra cycle
        if (state == ST_TS1 && bus.ts1_rcvd && ts1_cnt < TS1_MAX)
            ts1_nx = ts1_cnt + 8'd1;
        if (state == ST_TS2 && bus.ts2_rcvd && ts2_rx_cnt < TS2R_MAX)
            ts2_rx_nx = ts2_rx_cnt + 8'd1;
        if (state == ST_TS2 && bus.ts2_tx_done && ts2_tx_cnt < TS2T_MAX)
            ts2_tx_nx = ts2_tx_cnt + 8'd1;

        if (state == ST_TS1)
            fail_cond = bus.ttraining_error_timeout | bus.tgen4_ts1_timeout;
        else if (state == ST_TS2)
            fail_cond = bus.ttraining_error_timeout | bus.tgen4_ts2_timeout;

        if (bus.lane_disable) begin
            state_nx = ST_DISABLED;
        end else if ((state == ST_TS1 || state == ST_TS2 || state == ST_CL0) &&
                     bus.tdisconnect_rx_min) begin
            state_nx = ST_DISCONN;
        end else if (fail_cond) begin
            fail     = 1'b1;
            state_nx = (retry_cnt == LAST_TRY) ? ST_DISABLED : ST_DISCONN;
        end else begin
            case (state)
                ST_DISABLED: state_nx = (bus.tdisabled_min && !lane_fail_q) ? ST_DISCONN : ST_DISABLED;
                ST_DISCONN:  state_nx = (bus.tconnect_rx_min && bus.tdisconnect_tx_min) ? ST_TS1 : ST_DISCONN;
                ST_TS1:      state_nx = (ts1_nx >= TS1_MAX) ? ST_TS2 : ST_TS1;
                ST_TS2:      state_nx = (ts2_rx_nx >= TS2R_MAX && ts2_tx_nx >= TS2T_MAX) ? ST_CL0 : ST_TS2;
                ST_CL0:      state_nx = ST_CL0;
                default:     state_nx = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_DISABLED;
            ts1_cnt          <= '0;
            ts2_rx_cnt       <= '0;
            ts2_tx_cnt       <= '0;
            retry_cnt        <= '0;
            training_error_q <= 1'b0;
            lane_fail_q      <= 1'b0;
        end else begin
            state            <= state_nx;
            training_error_q <= fail;
            if (state_nx != state) begin
                ts1_cnt    <= '0;
                ts2_rx_cnt <= '0;
                ts2_tx_cnt <= '0;
            end else begin
                ts1_cnt    <= ts1_nx;
                ts2_rx_cnt <= ts2_rx_nx;
                ts2_tx_cnt <= ts2_tx_nx;
            end
            if (bus.lane_disable)
                retry_cnt <= '0;
            else if (fail)
                retry_cnt <= retry_cnt + 4'd1;
            else if (state_nx == ST_CL0 && state != ST_CL0)
                retry_cnt <= '0;
            if (bus.lane_disable)
                lane_fail_q <= 1'b0;
            else if (fail && retry_cnt == LAST_TRY)
                lane_fail_q <= 1'b1;
        end
    end

    assign bus.lane_state     = state;
    assign bus.fsm_disabled   = (state == ST_DISABLED);
    assign bus.disconnected_s = (state == ST_DISCONN);
    assign bus.fsm_training   = (state == ST_TS1) || (state == ST_TS2);
    assign bus.ts1_gen4_s     = (state == ST_TS1);
    assign bus.send_ts1       = (state == ST_TS1);
    assign bus.ts2_gen4_s     = (state == ST_TS2);
    assign bus.send_ts2       = (state == ST_TS2);
    assign bus.cl0_active     = (state == ST_CL0);
    assign bus.training_error = training_error_q;
    assign bus.lane_fail      = lane_fail_q;
endmodule

// File: tb/tb_lane_training_ctrl.sv
// tb/tb_lane_training_ctrl.sv - directed vector bench for lane_training_ctrl
module tb_lane_training_ctrl;
    logic sb_clk = 1'b0;
    logic rst    = 1'b0;
    always #5 sb_clk = ~sb_clk;

    lane_training_ctrl_if bus();

    lane_training_ctrl #(.TS1_REQ(2), .TS2_REQ(2), .TS2_SEND(16), .MAX_RETRY(3)) dut (
        .sb_clk (sb_clk),
        .rst    (rst),
        .bus    (bus)
    );

    localparam logic [10:0] LD  = 11'h001;
    localparam logic [10:0] TDM = 11'h002;
    localparam logic [10:0] TCR = 11'h004;
    localparam logic [10:0] TDT = 11'h008;
    localparam logic [10:0] TDR = 11'h010;
    localparam logic [10:0] TTE = 11'h020;
    localparam logic [10:0] T1O = 11'h040;
    localparam logic [10:0] T2O = 11'h080;
    localparam logic [10:0] R1  = 11'h100;
    localparam logic [10:0] R2  = 11'h200;
    localparam logic [10:0] TX  = 11'h400;
    localparam logic [10:0] CON = TCR | TDT;

    typedef struct {
        logic [10:0] in;
        int          rep;
        logic [2:0]  st;
        logic        te;
        logic        lf;
        logic [3:0]  retry;
    } vec_t;

    vec_t tbl[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [10:0] v);
        bus.lane_disable            = v[0];
        bus.tdisabled_min           = v[1];
        bus.tconnect_rx_min         = v[2];
        bus.tdisconnect_tx_min      = v[3];
        bus.tdisconnect_rx_min      = v[4];
        bus.ttraining_error_timeout = v[5];
        bus.tgen4_ts1_timeout       = v[6];
        bus.tgen4_ts2_timeout       = v[7];
        bus.ts1_rcvd                = v[8];
        bus.ts2_rcvd                = v[9];
        bus.ts2_tx_done             = v[10];
    endtask

    task automatic step(input logic [10:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            drive(v);
            @(posedge sb_clk);
            #1;
        end
        drive(11'h000);
    endtask

    // Expected enables: {fsm_disabled, disconnected_s, fsm_training, ts1_gen4_s, ts2_gen4_s, send_ts1, send_ts2, cl0_active}
    function automatic logic [7:0] decode(input logic [2:0] s);
        case (s)
            3'd0:    return 8'b1000_0000;
            3'd1:    return 8'b0100_0000;
            3'd2:    return 8'b0011_0100;
            3'd3:    return 8'b0010_1010;
            3'd4:    return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check_out(input string tag, input logic [2:0] s, input logic te, input logic lf);
        logic [7:0] dec;
        dec = {bus.fsm_disabled, bus.disconnected_s, bus.fsm_training, bus.ts1_gen4_s,
               bus.ts2_gen4_s, bus.send_ts1, bus.send_ts2, bus.cl0_active};
        check({tag, ".lane_state"}, 32'(bus.lane_state), 32'(s));
        check({tag, ".enables"}, 32'(dec), 32'(decode(s)));
        check({tag, ".training_error"}, 32'(bus.training_error), 32'(te));
        check({tag, ".lane_fail"}, 32'(bus.lane_fail), 32'(lf));
    endtask

    task automatic add(input logic [10:0] in, input int rep, input logic [2:0] st,
                       input logic te, input logic lf, input logic [3:0] r);
        vec_t v;
        v.in = in; v.rep = rep; v.st = st; v.te = te; v.lf = lf; v.retry = r;
        tbl.push_back(v);
    endtask

    initial begin
        // Nominal bring-up and TS2 partial
        add(TDM,      1, 3'd1, 0, 0, 4'd0);
        add(TCR,      1, 3'd1, 0, 0, 4'd0);
        add(CON,      1, 3'd2, 0, 0, 4'd0);
        add(R1,       1, 3'd2, 0, 0, 4'd0);
        add(11'h000,  1, 3'd2, 0, 0, 4'd0);
        add(R1,       1, 3'd3, 0, 0, 4'd0);
        add(R2,       1, 3'd3, 0, 0, 4'd0);
        add(TX,      16, 3'd3, 0, 0, 4'd0);
        add(R2,       1, 3'd4, 0, 0, 4'd0);
        // Disconnect from CL0, then retry exhaustion in TS1
        add(TDR,      1, 3'd1, 0, 0, 4'd0);
        add(CON,      1, 3'd2, 0, 0, 4'd0);
        add(T1O,      1, 3'd1, 1, 0, 4'd1);
        add(CON,      1, 3'd2, 0, 0, 4'd1);
        add(T1O,      1, 3'd1, 1, 0, 4'd2);
        add(CON,      1, 3'd2, 0, 0, 4'd2);
        add(T1O,      1, 3'd0, 1, 1, 4'd3);
        add(TDM,      3, 3'd0, 0, 1, 4'd3);
        add(LD | TDM, 1, 3'd0, 0, 0, 4'd0);
        // Collisions
        add(TDM,      1, 3'd1, 0, 0, 4'd0);
        add(CON,      1, 3'd2, 0, 0, 4'd0);
        add(R1,       1, 3'd2, 0, 0, 4'd0);
        add(R1 | T1O, 1, 3'd1, 1, 0, 4'd1);
        add(CON,      1, 3'd2, 0, 0, 4'd1);
        add(R1 | TDR | TTE, 1, 3'd1, 0, 0, 4'd1);
        add(CON,      1, 3'd2, 0, 0, 4'd1);
        add(R1,       2, 3'd3, 0, 0, 4'd1);
        add(TTE | R2, 1, 3'd1, 1, 0, 4'd2);
        add(CON,      1, 3'd2, 0, 0, 4'd2);
        add(R1,       2, 3'd3, 0, 0, 4'd2);
        add(TX,      16, 3'd3, 0, 0, 4'd2);
        add(R2,       2, 3'd4, 0, 0, 4'd0);
        add(TDR,      1, 3'd1, 0, 0, 4'd0);

        drive(11'h000);
        rst = 1'b0;
        repeat (2) @(posedge sb_clk);
        #1;
        check_out("reset", 3'd0, 0, 0);
        check("reset.retry_cnt", 32'(dut.retry_cnt), 0);
        check("reset.ts1_cnt", 32'(dut.ts1_cnt), 0);
        @(negedge sb_clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].rep);
            check_out($sformatf("row%0d", i), tbl[i].st, tbl[i].te, tbl[i].lf);
            check($sformatf("row%0d.retry_cnt", i), 32'(dut.retry_cnt), 32'(tbl[i].retry));
        end

        // Disconnect with nonzero counters clears them
        step(CON, 1);
        step(R1, 1);
        check("cnt.ts1_partial", 32'(dut.ts1_cnt), 1);
        step(R1, 1);
        step(R2 | TX, 1);
        check("cnt.ts2_rx", 32'(dut.ts2_rx_cnt), 1);
        check("cnt.ts2_tx", 32'(dut.ts2_tx_cnt), 1);
        step(TDR, 1);
        check_out("disc_ts2", 3'd1, 0, 0);
        check("disc.counters", 32'(dut.ts1_cnt) + 32'(dut.ts2_rx_cnt) + 32'(dut.ts2_tx_cnt), 0);

        // Exhaust retries with TS2 timeouts, then async reset while lane_fail is set
        for (int j = 0; j < 3; j++) begin
            step(CON, 1);
            step(R1, 2);
            check($sformatf("ex%0d.in_ts2", j), 32'(bus.lane_state), 3);
            step(T2O, 1);
            check_out($sformatf("ex%0d", j), (j < 2) ? 3'd1 : 3'd0, 1, (j == 2));
        end
        step(TDM, 2);
        check_out("fail_hold", 3'd0, 0, 1);
        #3 rst = 1'b0;
        #1;
        check_out("arst_fail", 3'd0, 0, 0);
        check("arst_fail.retry_cnt", 32'(dut.retry_cnt), 0);
        @(negedge sb_clk);
        rst = 1'b1;

        // Async reset mid-TS2
        step(TDM, 1);
        step(CON, 1);
        step(R1, 2);
        step(R2, 1);
        check_out("pre_arst_ts2", 3'd3, 0, 0);
        #3 rst = 1'b0;
        #1;
        check_out("arst_ts2", 3'd0, 0, 0);
        check("arst_ts2.ts2_rx_cnt", 32'(dut.ts2_rx_cnt), 0);
        @(negedge sb_clk);
        rst = 1'b1;
        step(11'h000, 2);
        check_out("post_arst_idle", 3'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
